core_inputs_ifc: RTL and testbench

CORE_INPUTS_IFC -- requirements
Module: core_inputs_ifc

---
 rtl/core_pkg.sv | 11 +
 rtl/core_inputs_ifc.sv | 93 +++++++++
 tb/tb_core_inputs_ifc.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared sizing constants and word type for the core input interface
package core_pkg;

    localparam int WIDTH       = 32;
    localparam int STATE_WORDS = 8;
    localparam int TAIL_WORDS  = 3;
    localparam int JOB_WORDS   = STATE_WORDS + TAIL_WORDS;

    typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/core_inputs_ifc.sv
// rtl/core_inputs_ifc.sv - serial word collector assembling hash state and tail per job
// Words land in shadow registers; the visible outputs change only when a job completes.
module core_inputs_ifc #(
    parameter int WIDTH       = core_pkg::WIDTH,
    parameter int STATE_WORDS = core_pkg::STATE_WORDS,
    parameter int TAIL_WORDS  = core_pkg::TAIL_WORDS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid,
    input  logic                          newblock,
    input  logic [WIDTH-1:0]              w1,
    output logic                          out_valid,
    output logic [STATE_WORDS*WIDTH-1:0]  hashstate,
    output logic [TAIL_WORDS*WIDTH-1:0]   tail,
    output logic                          busy,
    output logic                          proto_err
);

    localparam int N     = STATE_WORDS + TAIL_WORDS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [WIDTH-1:0]              shadow_q [N];
    logic [WIDTH-1:0]              shadow_d [N];
    logic [STATE_WORDS*WIDTH-1:0]  hashstate_q, hashstate_d;
    logic [TAIL_WORDS*WIDTH-1:0]   tail_q, tail_d;
    logic                          out_valid_q, out_valid_d;
    logic                          busy_q, busy_d;
    logic                          proto_err_q, proto_err_d;

    always_comb begin
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        hashstate_d = hashstate_q;
        tail_d      = tail_q;
        out_valid_d = 1'b0;
        proto_err_d = 1'b0;

        if (valid) begin
            if (newblock) begin
                // A new job always wins; an unfinished one is abandoned and flagged.
                shadow_d[0] = w1;
                cnt_d       = CNT_W'(1);
                proto_err_d = (cnt_q != '0);
            end else if (cnt_q == '0) begin
                proto_err_d = 1'b1;
            end else if (cnt_q == CNT_W'(N - 1)) begin
                shadow_d[N-1] = w1;
                cnt_d         = '0;
                out_valid_d   = 1'b1;
                for (int k = 0; k < STATE_WORDS; k++) begin
                    hashstate_d[(STATE_WORDS-1-k)*WIDTH +: WIDTH] = shadow_d[k];
                end
                for (int k = 0; k < TAIL_WORDS; k++) begin
                    tail_d[(TAIL_WORDS-1-k)*WIDTH +: WIDTH] = shadow_d[STATE_WORDS+k];
                end
            end else begin
                shadow_d[cnt_q] = w1;
                cnt_d           = cnt_q + CNT_W'(1);
            end
        end

        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            shadow_q    <= '{default: '0};
            hashstate_q <= '0;
            tail_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            hashstate_q <= hashstate_d;
            tail_q      <= tail_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign hashstate = hashstate_q;
    assign tail      = tail_q;
    assign busy      = busy_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_core_inputs_ifc.sv
// tb/tb_core_inputs_ifc.sv - directed and randomized bench for core_inputs_ifc against a queue model
module tb_core_inputs_ifc;
    import core_pkg::*;

    localparam int HW = STATE_WORDS * WIDTH;
    localparam int TW = TAIL_WORDS * WIDTH;

    logic          clk;
    logic          rst_n;
    logic          valid;
    logic          newblock;
    word_t         w1;
    logic          out_valid;
    logic [HW-1:0] hashstate;
    logic [TW-1:0] tail;
    logic          busy;
    logic          proto_err;

    core_inputs_ifc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (valid),
        .newblock  (newblock),
        .w1        (w1),
        .out_valid (out_valid),
        .hashstate (hashstate),
        .tail      (tail),
        .busy      (busy),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    word_t         job_q[$];
    logic [HW-1:0] exp_hash;
    logic [TW-1:0] exp_tail;
    logic          exp_ov;
    logic          exp_pe;

    int cyc = 0;
    int ov_count = 0;
    int pe_count = 0;
    int last_ov = -1;
    int prev_ov = -1;

    task automatic check(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        job_q.delete();
        exp_hash = '0;
        exp_tail = '0;
        exp_ov   = 1'b0;
        exp_pe   = 1'b0;
    endtask

    // Job semantics: a list of accepted words; emitting the list once it holds JOB_WORDS.
    task automatic model_step(input logic v, input logic nb, input word_t w);
        exp_ov = 1'b0;
        exp_pe = 1'b0;
        if (v) begin
            if (nb) begin
                exp_pe = (job_q.size() != 0);
                job_q.delete();
                job_q.push_back(w);
            end else if (job_q.size() == 0) begin
                exp_pe = 1'b1;
            end else begin
                job_q.push_back(w);
                if (job_q.size() == JOB_WORDS) begin
                    exp_hash = '0;
                    exp_tail = '0;
                    for (int k = 0; k < STATE_WORDS; k++) exp_hash = (exp_hash << WIDTH) | HW'(job_q[k]);
                    for (int k = 0; k < TAIL_WORDS; k++) exp_tail = (exp_tail << WIDTH) | TW'(job_q[STATE_WORDS+k]);
                    exp_ov = 1'b1;
                    job_q.delete();
                end
            end
        end
    endtask

    task automatic check_all();
        check("out_valid", HW'(out_valid), HW'(exp_ov));
        check("proto_err", HW'(proto_err), HW'(exp_pe));
        check("busy", HW'(busy), HW'(job_q.size() != 0));
        check("hashstate", hashstate, exp_hash);
        check("tail", HW'(tail), HW'(exp_tail));
    endtask

    task automatic cycle(input logic v, input logic nb, input word_t w);
        valid    = v;
        newblock = nb;
        w1       = w;
        @(posedge clk);
        model_step(v, nb, w);
        #1;
        cyc++;
        if (out_valid === 1'b1) begin
            ov_count++;
            prev_ov = last_ov;
            last_ov = cyc;
        end
        if (proto_err === 1'b1) pe_count++;
        check_all();
    endtask

    task automatic apply_reset();
        valid    = 1'b0;
        newblock = 1'b0;
        rst_n    = 1'b0;
        #1;
        model_clear();
        check_all();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
        rst_n = 1'b1;
    endtask

    task automatic send_job(input word_t base, input int max_gap);
        cycle(1'b1, 1'b1, base);
        for (int i = 1; i < JOB_WORDS; i++) begin
            if (max_gap > 0) begin
                int g = $urandom_range(max_gap, 1);
                for (int j = 0; j < g; j++) cycle(1'b0, 1'b0, word_t'($urandom));
            end
            cycle(1'b1, 1'b0, base + word_t'(i));
        end
    endtask

    initial begin
        int n0, p0;
        int r;
        clk      = 1'b0;
        rst_n    = 1'b0;
        valid    = 1'b0;
        newblock = 1'b0;
        w1       = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Single job, words 0..10 back to back
        n0 = ov_count;
        send_job(32'h0, 0);
        check("job_ov_latency", HW'(last_ov), HW'(cyc));
        check("job_hash", hashstate,
              256'h00000000_00000001_00000002_00000003_00000004_00000005_00000006_00000007);
        check("job_tail", HW'(tail), HW'(96'h00000008_00000009_0000000A));
        cycle(1'b0, 1'b0, '0);

        // Same job with idle gaps between words
        n0 = ov_count;
        send_job(32'h0, 3);
        repeat (3) cycle(1'b0, 1'b0, 32'hFFFF_FFFF);
        check("gap_ov_pulses", HW'(ov_count - n0), HW'(1));
        check("gap_hash", hashstate,
              256'h00000000_00000001_00000002_00000003_00000004_00000005_00000006_00000007);

        // Restart mid-job
        p0 = pe_count;
        cycle(1'b1, 1'b1, 32'h100);
        for (int i = 1; i < 5; i++) cycle(1'b1, 1'b0, 32'h100 + i);
        cycle(1'b1, 1'b1, 32'hDEADBEEF);
        for (int i = 1; i <= 10; i++) cycle(1'b1, 1'b0, i);
        cycle(1'b0, 1'b0, '0);
        check("restart_pe_pulses", HW'(pe_count - p0), HW'(1));
        check("restart_word0", HW'(hashstate[HW-1 -: 32]), HW'(32'hDEADBEEF));

        // Stray word while idle
        p0 = pe_count;
        cycle(1'b1, 1'b0, 32'h1234);
        check("idle_word_pe", HW'(proto_err), HW'(1'b1));
        check("idle_word_busy", HW'(busy), HW'(1'b0));
        cycle(1'b0, 1'b0, '0);

        // Reset mid-job, then a clean job
        n0 = ov_count;
        cycle(1'b1, 1'b1, 32'h500);
        for (int i = 1; i < 6; i++) cycle(1'b1, 1'b0, 32'h500 + i);
        apply_reset();
        check("reset_hash_zero", hashstate, '0);
        cycle(1'b1, 1'b0, 32'h777);
        cycle(1'b0, 1'b0, '0);
        check("reset_no_ov", HW'(ov_count - n0), HW'(0));
        send_job(32'h600, 0);
        check("post_reset_ov", HW'(ov_count - n0), HW'(1));

        // Two back-to-back jobs
        send_job(32'h1000, 0);
        send_job(32'h2000, 0);
        check("b2b_spacing", HW'(last_ov - prev_ov), HW'(JOB_WORDS));
        cycle(1'b0, 1'b0, '0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(999, 0));
            if (r < 4) begin
                apply_reset();
            end else if (r < 300) begin
                cycle(1'b0, ($urandom_range(1, 0) == 1), word_t'($urandom));
            end else if (job_q.size() == 0) begin
                cycle(1'b1, ($urandom_range(9, 0) < 8), word_t'($urandom));
            end else begin
                cycle(1'b1, ($urandom_range(99, 0) < 3), word_t'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
